// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers (round-robin, optional burst lock).
// Latency: request seen in IDLE -> grant and tx_data_ready on the next cycle; one idle cycle follows each done.
// Backpressure: a single byte is in flight; requesters hold req/req_data until grant; no hang timeout.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req, req_lock      per-requester byte request / burst-hold request (levels)
//   req_data           byte of requester i at [i*BITS +: BITS]
//   grant, done        one-hot 1-cycle pulses: byte captured / byte frame finished
//   busy               high whenever the sequencer is not IDLE
//   tx_data, tx_data_ready, tx_data_sent   transmitter handshake
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BITS      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ*BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [BITS-1:0]         tx_data,
  output logic                    tx_data_ready,
  input  logic                    tx_data_sent
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [BITS-1:0]     tx_data_q, tx_data_d;
  logic                tx_rdy_q, tx_rdy_d;
  logic                busy_q, busy_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       burst_q, burst_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic                lock_q, lock_d;

  logic [BITS-1:0]     req_bytes [NUM_REQ];
  logic [PW-1:0]       rr_idx;
  logic                rr_found;
  logic [PW-1:0]       cand;
  logic                lock_ok;
  logic [PW-1:0]       win_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*BITS +: BITS];
    end
  end

  // Round-robin scan starting just after the pointer, wrapping; the pointer
  // itself is checked last so the previous winner has lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // lock_q holds the owner's req_lock as sampled on its done edge.
  assign lock_ok = lock_q && req[owner_q] && (burst_q < CW'(MAX_BURST));
  assign win_idx = lock_ok ? owner_q : rr_idx;

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    done_d    = '0;
    tx_data_d = tx_data_q;
    tx_rdy_d  = 1'b0;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    case (state_q)
      S_IDLE: begin
        // The done cycle itself does not arbitrate, which gives the
        // one-cycle gap and lets requesters react to done.
        if (!done_q && (req != '0)) begin
          grant_d[win_idx] = 1'b1;
          tx_data_d        = req_bytes[win_idx];
          tx_rdy_d         = 1'b1;
          owner_d          = win_idx;
          if (lock_ok) begin
            burst_d = burst_q + CW'(1);
          end else begin
            ptr_d   = rr_idx;
            burst_d = CW'(1);
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // Ignore the high level left over from the previous frame.
        if (!tx_data_sent) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (tx_data_sent) begin
          done_d[owner_q] = 1'b1;
          lock_d          = req_lock[owner_q];
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= PW'(NUM_REQ - 1);
      burst_q   <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign tx_data       = tx_data_q;
  assign tx_data_ready = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand sequences for reset/stale/withdraw, random txns.
// Latency: transaction-level; a transmitter model answers tx_data_ready after a programmable frame.
// Backpressure: one byte outstanding at a time, as the arbiter enforces.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int BITS = 8;
  localparam int MB   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_lock = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant, done;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_data_ready;
  logic        tx_data_sent = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .BITS(BITS), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_data(req_data),
    .grant(grant), .done(done), .busy(busy), .tx_data(tx_data),
    .tx_data_ready(tx_data_ready), .tx_data_sent(tx_data_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Transmitter model: sent drops low_dly cycles after accept, rises frame_len cycles after accept.
  int low_dly = 1;
  int frame_len = 5;
  int tx_cnt = 0;
  int n_accept = 0;
  bit tx_active = 1'b0;
  bit tx_fell = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      tx_active    = 1'b0;
      tx_data_sent = 1'b1;
      tx_cnt       = 0;
    end else if (tx_data_ready) begin
      tx_active = 1'b1;
      tx_cnt    = 0;
      tx_fell   = 1'b0;
      n_accept++;
    end else if (tx_active) begin
      tx_cnt++;
      if (tx_cnt == low_dly) begin
        tx_data_sent = 1'b0;
        tx_fell      = 1'b1;
      end
      if (tx_cnt == frame_len) begin
        tx_data_sent = 1'b1;
        tx_active    = 1'b0;
      end
    end
  end

  // Protocol monitor on every pulse.
  int n_grant = 0;
  int n_grant3 = 0;
  always @(negedge clk) begin
    if (rst && (grant != '0 || done != '0)) begin
      if (grant != '0) begin
        n_grant++;
        if (grant[3]) n_grant3++;
      end
      check("mon_onehot", 32'($onehot0(grant) && $onehot0(done)), 32'd1);
      check("mon_grant_done_excl", 32'((grant != '0) && (done != '0)), 32'd0);
      check("mon_grant_with_ready", 32'(grant != '0), 32'(tx_data_ready));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    req_lock = '0;
    #1;
    check("rst_outputs", 32'({grant, done, tx_data, tx_data_ready, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called on a negedge with the arbiter idle (reset just released, or done just seen).
  task automatic do_txn(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                        input int win, input int lat, input string tag);
    int t;
    logic [3:0] exp_oh;
    logic [7:0] exp_b;
    exp_oh = 4'b0001 << win;
    exp_b = d[win*8 +: 8];
    req = r;
    req_lock = l;
    req_data = d;
    t = 0;
    while (grant == '0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (grant == '0) begin
      timeout({tag, "_grant"});
    end else begin
      check({tag, "_grant"}, 32'(grant), 32'(exp_oh));
      check({tag, "_txdata"}, 32'(tx_data), 32'(exp_b));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (lat >= 0) check({tag, "_latency"}, 32'(t), 32'(lat));
      @(negedge clk);
      check({tag, "_pulse_len"}, 32'({grant, tx_data_ready}), 32'd0);
      t = 0;
      while (done == '0 && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (done == '0) begin
        timeout({tag, "_done"});
      end else begin
        check({tag, "_done"}, 32'(done), 32'(exp_oh));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_frame_complete"}, 32'(tx_fell && !tx_active), 32'd1);
      end
    end
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_oh);
    int t;
    t = 0;
    while (grant == '0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (grant == '0) timeout(tag);
    else check(tag, 32'(grant), 32'(exp_oh));
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_oh);
    int t;
    t = 0;
    while (done == '0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (done == '0) timeout(tag);
    else check(tag, 32'(done), 32'(exp_oh));
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  r;
    logic [3:0]  l;
    logic [31:0] d;
    int          win;
    int          lat;
  } vec_t;

  vec_t tv[17];
  int   w3[7] = '{2, 2, 0, 2, 2, 2, 0};

  initial begin
    int t, g3, win;
    int m_ptr, m_burst, m_owner;
    bit m_lock;
    logic [3:0] r, l;
    logic [31:0] d;

    // Single byte, then round-robin from reset, then lock with MAX_BURST=3.
    tv[0] = '{1'b1, 4'b0001, 4'b0000, 32'h000000A5, 0, 1};
    for (int i = 0; i < 8; i++)
      tv[1+i] = '{(i == 0), 4'b1111, 4'b0000, $urandom, i % 4, (i == 0) ? 1 : 2};
    tv[9] = '{1'b0, 4'b0100, 4'b0100, $urandom, 2, 2};
    for (int i = 0; i < 7; i++)
      tv[10+i] = '{1'b0, 4'b0101, 4'b0100, $urandom, w3[i], 2};

    for (int i = 0; i < 17; i++) begin
      if (tv[i].rst) do_reset();
      do_txn(tv[i].r, tv[i].l, tv[i].d, tv[i].win, tv[i].lat, $sformatf("vec%0d", i));
    end
    req = '0;
    req_lock = '0;

    // Stale sent: the transmitter keeps sent high for 2 cycles after accept.
    low_dly = 2;
    do_txn(4'b0001, 4'b0000, $urandom, 0, 2, "stale");
    low_dly = 1;
    req = '0;

    // Withdraw: requester 3 would win after 2, but drops req before its grant.
    req_data = $urandom;
    req = 4'b0100;
    wait_grant("wd_first_grant", 4'b0100);
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    req = 4'b0010;
    g3 = n_grant3;
    wait_done("wd_first_done", 4'b0100);
    wait_grant("wd_grant_1", 4'b0010);
    req = '0;
    wait_done("wd_done_1", 4'b0010);
    repeat (5) @(negedge clk);
    check("wd_no_grant_3", 32'(n_grant3 - g3), 32'd0);

    // Reset while waiting for the frame to end, owner = 1.
    frame_len = 12;
    req = 4'b0010;
    wait_grant("mid_rst_grant", 4'b0010);
    req = '0;
    t = 0;
    while (tx_data_sent && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (tx_data_sent) timeout("mid_rst_sent_low");
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_async", 32'({grant, done, tx_data, tx_data_ready, busy}), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'({grant, done}), 32'd0);
    rst = 1'b1;
    frame_len = 5;
    @(negedge clk);
    do_txn(4'b0010, 4'b0000, $urandom, 1, 1, "post_rst");
    do_txn(4'b0011, 4'b0000, $urandom, 0, 2, "post_rst_prio");
    req = '0;

    // Random transactions against a rule-level model.
    do_reset();
    m_ptr = NREQ - 1;
    m_burst = 0;
    m_owner = 0;
    m_lock = 1'b0;
    for (int k = 0; k < 40; k++) begin
      r = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) r[m_owner] = 1'b1;
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) l = 4'hF;
      d = $urandom;
      frame_len = $urandom_range(3, 8);
      if (m_lock && r[m_owner] && m_burst < MB) begin
        win = m_owner;
        m_burst++;
      end else begin
        win = -1;
        for (int s = 1; s <= NREQ; s++) begin
          int c;
          c = (m_ptr + s) % NREQ;
          if (win < 0 && r[c]) win = c;
        end
        m_ptr = win;
        m_burst = 1;
      end
      m_owner = win;
      do_txn(r, l, d, win, (k == 0) ? 1 : 2, $sformatf("rnd%0d", k));
      m_lock = l[win];
    end
    req = '0;
    repeat (4) @(negedge clk);

    check("bytes_per_grant", 32'(n_accept), 32'(n_grant));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
